// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_timeout_ctr.sv
// Loadable up-counter; expire is high while the count sits at LIMIT-1.
module mem_arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 64,
  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          expire
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expire = (count_q == CW'(LIMIT - 1));
  assign count  = count_q;

  // Holding at the limit keeps expire asserted if the owner lingers.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS): one outstanding
// transaction, fixed LS priority with an IF anti-starvation streak limit, response timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_LS_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [STRB_W-1:0] ls_wstrb,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_e        dbg_state
);

  // Handshake: a requester holds *_req with stable fields until *_gnt is seen high
  // in the same cycle; mem_req holds stable fields until mem_gnt; every granted
  // transaction ends with exactly one *_rvalid pulse (err=1 on timeout) unless reset.

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [SW-1:0]     streak_q, streak_d;

  logic              if_win;
  logic              if_gnt_c, ls_gnt_c;
  logic              tmr_load, tmr_en, tmr_expire;
  logic [TW-1:0]     tmr_count;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_data;

  mem_arb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  // IF only beats a pending LS once the LS streak has hit its limit.
  assign if_win = if_req && (!ls_req || (streak_q == STREAK_MAX));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    streak_d   = streak_q;
    if_gnt_c   = 1'b0;
    ls_gnt_c   = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    case (state_q)
      IDLE: begin
        if (if_win) begin
          if_gnt_c = 1'b1;
          owner_d  = OWN_IF;
          we_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          wstrb_d  = '0;
          streak_d = '0;
          tmr_load = 1'b1;
          state_d  = REQ;
        end else if (ls_req) begin
          ls_gnt_c = 1'b1;
          owner_d  = OWN_LS;
          we_d     = ls_we;
          addr_d   = ls_addr;
          wdata_d  = ls_wdata;
          wstrb_d  = ls_wstrb;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
          tmr_load = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (mem_rvalid) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_rdata;
          state_d   = IDLE;
        end else if (tmr_expire) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      streak_q <= streak_d;
    end
  end

  // Grants are combinational from the inputs, so mask them while reset is held.
  assign if_gnt    = if_gnt_c & rst;
  assign ls_gnt    = ls_gnt_c & rst;

  assign mem_req   = (state_q == REQ) && !tmr_expire;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  assign if_rvalid = rsp_valid && (owner_q == OWN_IF);
  assign if_err    = rsp_err && (owner_q == OWN_IF);
  assign if_rdata  = (owner_q == OWN_IF) ? rsp_data : '0;
  assign ls_rvalid = rsp_valid && (owner_q == OWN_LS);
  assign ls_err    = rsp_err && (owner_q == OWN_LS);
  assign ls_rdata  = (owner_q == OWN_LS) ? rsp_data : '0;

  assign dbg_state = state_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Sits between the pipeline front/back ends and the memory model inside top. One outstanding transaction at a time.
- Fixed LS priority, with an anti-starvation streak limit for IF and a response timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB_W = DATA_W/8.
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF waits.
- TIMEOUT_CYCLES, 64, cycles in REQ+WAIT before abort; minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  request captured this cycle.
- if_rvalid  out  1  fetch response valid (1-cycle pulse).
- if_rdata  out  DATA_W  fetch data.
- if_err  out  1  qualifies if_rvalid; 1 means timeout.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_wstrb  in  STRB_W  byte enables.
- ls_gnt, ls_rvalid, ls_rdata, ls_err  out  as the IF equivalents; stores also receive ls_rvalid (ack).
- mem_req  out  1  memory request.
- mem_we  out  1  store flag to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data to memory.
- mem_wstrb  out  STRB_W  byte enables to memory.
- mem_gnt  in  1  memory accepted mem_req this cycle.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  DATA_W  memory response data.

Behaviour:
- States: IDLE, REQ, WAIT. Owner register: IF or LS.
- Reset (rst=0, async):
  - state=IDLE; mem_req=0; all mem_* outputs 0; holding regs 0.
  - streak=0; timer=0; all gnt, rvalid and err outputs 0; rdata outputs 0.
- IDLE arbitration, combinational:
  - ls_req wins, unless if_req=1 and streak==MAX_LS_STREAK, in which case IF wins.
  - Winner's gnt=1 this cycle. Request fields and owner are latched; next state REQ.
  - IF read sets mem_we=0, mem_wstrb=0, mem_wdata=0.
- Streak counter:
  - Increments on each LS grant while if_req=1, saturating at MAX_LS_STREAK.
  - Clears on any IF grant, and on an LS grant when if_req=0.
- REQ: mem_req=1 with latched fields, stable until mem_gnt. On mem_gnt go to WAIT next cycle; mem_req=0 from WAIT.
- WAIT: mem_rvalid=1 drives owner's rvalid=1 and rdata=mem_rdata combinationally in the same cycle, err=0; next state IDLE.
- Non-owner rvalid is always 0. Outputs are unaffected by mem_rvalid outside WAIT (spurious, ignored).
- Latency:
  - Req seen in IDLE at cycle 0: gnt at cycle 0, mem_req at cycle 1.
  - With mem_gnt at 1 and mem_rvalid at 2: rvalid at cycle 2, IDLE at cycle 3.
  - Peak rate is 1 transaction per 3 cycles.
- Timeout:
  - timer clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When timer==TIMEOUT_CYCLES-1 and no completion that cycle: owner rvalid=1, err=1, rdata=0, mem_req dropped; next state IDLE.
  - mem_gnt and mem_rvalid in that same cycle: completion wins (err=0).
  - A late mem_rvalid after abort is ignored.
- Requests arriving outside IDLE are not granted and must stay held.
- Reset mid-transaction: immediate return to IDLE; the transaction is lost and no rvalid is issued.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (IDLE/REQ/WAIT);
  - owner enum (OWN_IF/OWN_LS);
  - default widths ADDR_W/DATA_W.
- One sub-module: mem_arb_timeout_ctr, a loadable up-counter with an expire flag.

Test Plan:
- IF-only read: if_req, addr 0x0000_0010; mem_gnt at cycle 1; mem_rvalid at cycle 2 with 0xDEADBEEF. Expect if_gnt at 0, mem_req at 1, if_rvalid and if_rdata=0xDEADBEEF at 2, if_err=0.
- Simultaneous requests: if_req=1 and ls_req=1 (store, addr 0x100, wdata 0x12345678, wstrb 0xF). Expect ls_gnt first with mem_we=1 and mem_wstrb=0xF; IF granted in the next IDLE; ls_rvalid (ack) before if_rvalid.
- Starvation: ls_req=1 and if_req=1 held continuously, MAX_LS_STREAK=4. Expect exactly 4 LS grants, then if_gnt, then LS again; streak=0 after the IF grant.
- Timeout: LS load, mem_gnt=1, mem_rvalid never asserted, TIMEOUT_CYCLES=64. Expect ls_rvalid=1, ls_err=1, ls_rdata=0 at 63 cycles after REQ entry, then IDLE. A later mem_rvalid produces no output.
- Stalled memory: mem_gnt held low 10 cycles. Expect mem_req and mem_addr stable, no new gnt; an if_req raised meanwhile is granted only after return to IDLE.
- Reset mid-WAIT: rst=0 for 2 cycles during WAIT. Expect all outputs 0 asynchronously, state IDLE, no rvalid; a new request after reset completes normally.
